alarm_clock: RTL
================

ALARM_CLOCK -- requirements
Module: alarm_clock

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, clock cycles per second (>= 2).
REQ-002 Parameter H24, default 1: 1 = 24-hour format (00..23); 0 = 12-hour format (01..12 plus pm flag).
REQ-003 Parameter ALARM_SEC, default 60, number of seconds alarm_out stays asserted unless dismissed (1..255).
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 btn_mode  in  1  one-cycle pulse, debounced upstream; advances the set mode.
REQ-007 btn_inc  in  1  one-cycle pulse, debounced upstream; increments the selected field or dismisses the alarm.
REQ-008 alarm_en  in  1  level; 1 arms the alarm.
REQ-009 h1, h0, m1, m0, s1, s0  out  4 each  BCD display digits.
REQ-010 pm  out  1  pm flag of the displayed hour; always 0 when H24=1.
REQ-011 mode  out  3  current state encoding: 0 RUN, 1 SET_MIN, 2 SET_HOUR, 3 SET_AMIN, 4 SET_AHOUR.
REQ-012 tick_1hz  out  1  one-cycle pulse on each counted second (RUN only).
REQ-013 alarm_out  out  1  alarm ringing indicator.

Function
REQ-014 Prescaler SHALL count 0..CLK_HZ-1 in RUN; tick_1hz SHALL assert in the cycle the prescaler equals CLK_HZ-1, and the prescaler wraps to 0 in the same cycle.
REQ-015 On tick: seconds 00..59; carry into minutes 00..59; carry into hours; all outputs SHALL update on the clock edge after the tick cycle (latency 1).
REQ-016 Hours, H24=1: 00..23, 23 -> 00. H24=0: 12 -> 01 -> ... -> 11 -> 12, pm toggles on the 11 -> 12 transition.
REQ-017 Digits SHALL never hold a non-BCD value or a value outside its field range.
REQ-018 State machine: btn_mode moves RUN -> SET_MIN -> SET_HOUR -> SET_AMIN -> SET_AHOUR -> RUN; one transition per pulse.
REQ-019 In the SET states, the prescaler and seconds SHALL be frozen and tick_1hz SHALL stay 0.
REQ-020 SET_MIN / SET_HOUR: btn_inc increments the time minute / hour, wrapping with no carry into the next field. The hour wrap follows REQ-016, including the pm toggle.
REQ-021 SET_AMIN / SET_AHOUR: btn_inc increments the alarm minute / hour registers with the same wrap rules; the time registers SHALL NOT change.
REQ-022 Display SHALL show alarm hh:mm (s1=s0=0, pm = alarm pm) in SET_AMIN and SET_AHOUR, and the time in all other states.
REQ-023 Leaving SET_HOUR -> SET_AMIN: seconds and prescaler cleared to 0.
REQ-024 Leaving SET_AHOUR -> RUN: prescaler cleared; time seconds not changed.
REQ-025 btn_mode and btn_inc in the same cycle: btn_mode is acted on and btn_inc is ignored.
REQ-026 Alarm trigger: in RUN with alarm_en=1, when a tick makes the time equal to the alarm hh:mm:00 (pm included when H24=0), alarm_out SHALL rise on that same update edge.
REQ-027 alarm_out SHALL deassert after ALARM_SEC ticks, or on the edge after btn_inc in RUN, or immediately when alarm_en=0 or the state leaves RUN, whichever comes first.
REQ-028 btn_inc in RUN while alarm_out=0 SHALL have no effect.
REQ-029 A new match while alarm_out=1 SHALL restart the ALARM_SEC count.

Reset
REQ-030 Reset SHALL override all other inputs in the cycle it is sampled.
REQ-031 Reset values:
  - mode=RUN, prescaler=0, seconds 00, tick_1hz=0, alarm_out=0, alarm-duration counter=0.
  - H24=1: time 00:00:00 and alarm 00:00.
  - H24=0: time 12:00:00 pm=0 and alarm 12:00 pm=0.
REQ-032 Reset asserted mid-set or mid-alarm SHALL return to the reset values on the next edge, with no residual state.

Verification (CLK_HZ=4, ALARM_SEC=3 unless stated)
REQ-033 Scenario 1, H24=1: preset 23:59:58 via SET states, then run 2 s -> tick_1hz every 4 cycles; display 23:59:59 then 00:00:00.
REQ-034 Scenario 2, H24=0: preset 11:59:59 pm=0, one tick -> 12:00:00 pm=1. Then 12:59:59 plus one tick -> 01:00:00 pm=1.
REQ-035 Scenario 3, alarm: alarm 00:01, alarm_en=1, run from 00:00:00 -> alarm_out rises at 00:01:00 and falls at 00:01:03. Repeat with btn_inc at 00:01:01 -> alarm_out falls one cycle after the pulse.
REQ-036 Scenario 4: btn_mode and btn_inc in the same cycle in SET_MIN -> mode=SET_HOUR, minutes unchanged. btn_inc in SET_MIN at 59 -> 00 with hours unchanged.
REQ-037 Scenario 5: reset pulse while in SET_AHOUR with alarm_out context active -> next cycle mode=0, all digits at reset values, alarm_out=0, alarm register restored.
REQ-038 Scenario 6: in SET_AMIN, btn_inc x3 -> display shows alarm 00:03 while time is frozen. Return to RUN -> time display resumes from the frozen value.

Source files
------------

// File: rtl/alarm_clock.sv
// Alarm clock: prescaled seconds counter, hh:mm:ss time of day,
// button-driven set modes and a timed alarm with dismiss.
module alarm_clock #(
   parameter int CLK_HZ    = 50_000_000,
   parameter int H24       = 1,
   parameter int ALARM_SEC = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       alarm_en,
   output logic [3:0] h1,
   output logic [3:0] h0,
   output logic [3:0] m1,
   output logic [3:0] m0,
   output logic [3:0] s1,
   output logic [3:0] s0,
   output logic       pm,
   output logic [2:0] mode,
   output logic       tick_1hz,
   output logic       alarm_out
);

   localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0] PMAX = PW'(CLK_HZ - 1);
   localparam bit IS24 = (H24 != 0);
   localparam logic [4:0] HRST = IS24 ? 5'd0 : 5'd12;
   localparam logic [7:0] ACNT = 8'(ALARM_SEC);

   typedef enum logic [2:0] {
      RUN       = 3'd0,
      SET_MIN   = 3'd1,
      SET_HOUR  = 3'd2,
      SET_AMIN  = 3'd3,
      SET_AHOUR = 3'd4
   } state_t;

   state_t state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [5:0] sec_q, sec_d;
   logic [5:0] min_q, min_d;
   logic [4:0] hour_q, hour_d;
   logic pm_q, pm_d;
   logic [5:0] amin_q, amin_d;
   logic [4:0] ahour_q, ahour_d;
   logic apm_q, apm_d;
   logic alarm_q, alarm_d;
   logic [7:0] acnt_q, acnt_d;
   logic tick, inc_go, match;

   function automatic logic [5:0] inc60(input logic [5:0] v);
      return (v == 6'd59) ? 6'd0 : v + 6'd1;
   endfunction

   // Returns {pm, hour} after one hour step.
   function automatic logic [5:0] inc_hour(input logic [4:0] h,
                                           input logic p);
      logic [4:0] hn;
      logic pn;
      hn = h + 5'd1;
      pn = p;
      if (IS24) begin
         if (h == 5'd23) hn = 5'd0;
         pn = 1'b0;
      end else begin
         if (h == 5'd12) hn = 5'd1;
         else if (h == 5'd11) pn = ~p;
      end
      return {pn, hn};
   endfunction

   function automatic logic [7:0] to_bcd(input logic [5:0] v);
      logic [5:0] t, u;
      t = v / 6'd10;
      u = v % 6'd10;
      return {t[3:0], u[3:0]};
   endfunction

   // Next-state: time counting, set-mode FSM and alarm control.
   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      sec_d   = sec_q;
      min_d   = min_q;
      hour_d  = hour_q;
      pm_d    = pm_q;
      amin_d  = amin_q;
      ahour_d = ahour_q;
      apm_d   = apm_q;
      alarm_d = alarm_q;
      acnt_d  = acnt_q;
      tick    = (state_q == RUN) && (presc_q == PMAX);
      inc_go  = btn_inc && !btn_mode;

      if (state_q == RUN) begin
         presc_d = tick ? '0 : presc_q + PW'(1);
         if (tick) begin
            sec_d = inc60(sec_q);
            if (sec_q == 6'd59) begin
               min_d = inc60(min_q);
               if (min_q == 6'd59)
                  {pm_d, hour_d} = inc_hour(hour_q, pm_q);
            end
         end
      end

      unique case (state_q)
         RUN: begin
            if (btn_mode) state_d = SET_MIN;
         end
         SET_MIN: begin
            if (btn_mode) state_d = SET_HOUR;
            else if (inc_go) min_d = inc60(min_q);
         end
         SET_HOUR: begin
            if (btn_mode) begin
               state_d = SET_AMIN;
               sec_d   = 6'd0;
               presc_d = '0;
            end else if (inc_go) begin
               {pm_d, hour_d} = inc_hour(hour_q, pm_q);
            end
         end
         SET_AMIN: begin
            if (btn_mode) state_d = SET_AHOUR;
            else if (inc_go) amin_d = inc60(amin_q);
         end
         SET_AHOUR: begin
            if (btn_mode) begin
               state_d = RUN;
               presc_d = '0;
            end else if (inc_go) begin
               {apm_d, ahour_d} = inc_hour(ahour_q, apm_q);
            end
         end
         default: state_d = RUN;
      endcase

      match = tick && alarm_en && (sec_d == 6'd0) &&
              (min_d == amin_q) && (hour_d == ahour_q) &&
              (pm_d == apm_q);

      if (state_q != RUN || !alarm_en || btn_mode) begin
         alarm_d = 1'b0;
         acnt_d  = 8'd0;
      end else if (match) begin
         alarm_d = 1'b1;
         acnt_d  = ACNT;
      end else if (alarm_q && btn_inc) begin
         alarm_d = 1'b0;
         acnt_d  = 8'd0;
      end else if (alarm_q && tick) begin
         if (acnt_q <= 8'd1) begin
            alarm_d = 1'b0;
            acnt_d  = 8'd0;
         end else begin
            acnt_d = acnt_q - 8'd1;
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         presc_q <= '0;
         sec_q   <= 6'd0;
         min_q   <= 6'd0;
         hour_q  <= HRST;
         pm_q    <= 1'b0;
         amin_q  <= 6'd0;
         ahour_q <= HRST;
         apm_q   <= 1'b0;
         alarm_q <= 1'b0;
         acnt_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         sec_q   <= sec_d;
         min_q   <= min_d;
         hour_q  <= hour_d;
         pm_q    <= pm_d;
         amin_q  <= amin_d;
         ahour_q <= ahour_d;
         apm_q   <= apm_d;
         alarm_q <= alarm_d;
         acnt_q  <= acnt_d;
      end
   end

   // Display mux: alarm hh:mm while editing it, time otherwise.
   always_comb begin
      logic show_alarm;
      show_alarm = (state_q == SET_AMIN) || (state_q == SET_AHOUR);
      if (show_alarm) begin
         {h1, h0} = to_bcd({1'b0, ahour_q});
         {m1, m0} = to_bcd(amin_q);
         {s1, s0} = 8'h00;
         pm       = apm_q;
      end else begin
         {h1, h0} = to_bcd({1'b0, hour_q});
         {m1, m0} = to_bcd(min_q);
         {s1, s0} = to_bcd(sec_q);
         pm       = pm_q;
      end
   end

   assign mode      = state_q;
   assign tick_1hz  = tick;
   assign alarm_out = alarm_q && alarm_en && (state_q == RUN);

endmodule
